// File: rtl/sm4_axis_mode_ctrl.sv
// rtl/sm4_axis_mode_ctrl.sv - SM4 AXI-stream ECB/CBC mode controller driving an external block core
// Optional statistics outputs stat_blocks/stat_pkts under macro SM4_AXIS_STATS_EN.
module sm4_axis_mode_ctrl #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 4,
    parameter int KEY_WAIT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_vld,
    output logic               cfg_rdy,
    input  logic [127:0]       cfg_key,
    input  logic               cfg_sel,
    input  logic               cfg_mode,
    input  logic [127:0]       cfg_iv,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic               core_key_vld,
    output logic [127:0]       core_key,
    output logic               core_sel,
    output logic [127:0]       core_in_data,
    output logic               core_in_vld,
    input  logic               core_in_rdy,
    input  logic [127:0]       core_out_data,
    input  logic               core_out_vld,
    output logic               err_partial
`ifdef SM4_AXIS_STATS_EN
    ,
    output logic [31:0]        stat_blocks,
    output logic [31:0]        stat_pkts
`endif
);
    localparam int BEATS = 128 / DATA_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int KW    = $clog2(KEY_WAIT + 1);
    localparam logic [1:0]    LAST_BEAT = 2'(BEATS - 1);
    localparam logic [PW+1:0] DEPTH_L   = (PW + 2)'(DEPTH);

    logic [KW-1:0] kw_cnt;
    logic          mode_r;
    logic [127:0]  iv_r;
    logic [127:0]  chain;

    logic [127:0]  gb_data;
    logic [127:0]  gb_next;
    logic [1:0]    gb_cnt;
    logic          gb_full;
    logic          gb_last;

    logic          side_last [DEPTH];
    logic [127:0]  side_mask [DEPTH];
    logic [PW-1:0] side_wr;
    logic [PW-1:0] side_rd;
    logic [PW:0]   inflight;

    logic [127:0]  res_mem  [DEPTH];
    logic          res_last [DEPTH];
    logic [PW-1:0] res_wr;
    logic [PW-1:0] res_rd;
    logic [PW:0]   res_cnt;
    logic [1:0]    ob_cnt;

    logic idle, cbc_enc, cbc_dec, credit, issue, result, s_fire, m_fire, pop;

    assign idle          = !gb_full && (gb_cnt == 2'd0) && (inflight == '0) && (res_cnt == '0);
    assign cfg_rdy       = idle && (kw_cnt == '0);
    assign s_axis_tready = !gb_full && (kw_cnt == '0);
    assign cbc_enc       = mode_r && !core_sel;
    assign cbc_dec       = mode_r && core_sel;
    assign credit        = ({1'b0, inflight} + {1'b0, res_cnt}) < DEPTH_L;
    // CBC encrypt needs the previous ciphertext as chain, so only one block may be in flight.
    assign issue         = gb_full && core_in_rdy && credit && (!cbc_enc || (inflight == '0));
    assign core_in_vld   = issue;
    assign core_in_data  = cbc_enc ? (gb_data ^ chain) : gb_data;
    // Results from before a reset find no side-FIFO entry and are dropped.
    assign result        = core_out_vld && (inflight != '0);
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    // The unpacker reads straight from the result FIFO head; an entry is popped after its last beat.
    assign m_axis_tvalid = (res_cnt != '0);
    assign m_axis_tdata  = m_axis_tvalid ? res_mem[res_rd][127 - int'(ob_cnt) * DATA_W -: DATA_W] : '0;
    assign m_axis_tlast  = m_axis_tvalid && res_last[res_rd] && (ob_cnt == LAST_BEAT);
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign pop           = m_fire && (ob_cnt == LAST_BEAT);

    // Starting a new block clears the buffer so a short final block is zero padded.
    always_comb begin
        gb_next = (gb_cnt == 2'd0) ? '0 : gb_data;
        gb_next[127 - int'(gb_cnt) * DATA_W -: DATA_W] = s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kw_cnt       <= KW'(KEY_WAIT);
            mode_r       <= 1'b0;
            iv_r         <= '0;
            chain        <= '0;
            core_key     <= '0;
            core_sel     <= 1'b0;
            core_key_vld <= 1'b0;
            gb_data      <= '0;
            gb_cnt       <= 2'd0;
            gb_full      <= 1'b0;
            gb_last      <= 1'b0;
            side_wr      <= '0;
            side_rd      <= '0;
            inflight     <= '0;
            res_wr       <= '0;
            res_rd       <= '0;
            res_cnt      <= '0;
            ob_cnt       <= 2'd0;
            err_partial  <= 1'b0;
        end else begin
            core_key_vld <= 1'b0;
            if (kw_cnt != '0)
                kw_cnt <= kw_cnt - 1'b1;
            if (cfg_vld && cfg_rdy) begin
                core_key     <= cfg_key;
                core_sel     <= cfg_sel;
                mode_r       <= cfg_mode;
                iv_r         <= cfg_iv;
                chain        <= cfg_iv;
                core_key_vld <= 1'b1;
                kw_cnt       <= KW'(KEY_WAIT);
            end

            if (s_fire) begin
                gb_data <= gb_next;
                if ((gb_cnt == LAST_BEAT) || s_axis_tlast) begin
                    gb_full <= 1'b1;
                    gb_last <= s_axis_tlast;
                    gb_cnt  <= 2'd0;
                    if (s_axis_tlast && (gb_cnt != LAST_BEAT))
                        err_partial <= 1'b1;
                end else begin
                    gb_cnt <= gb_cnt + 1'b1;
                end
            end

            if (issue) begin
                gb_full            <= 1'b0;
                side_last[side_wr] <= gb_last;
                side_mask[side_wr] <= cbc_dec ? chain : '0;
                side_wr            <= side_wr + 1'b1;
                if (cbc_dec)
                    chain <= gb_last ? iv_r : gb_data;
            end

            if (result) begin
                res_mem[res_wr]  <= core_out_data ^ side_mask[side_rd];
                res_last[res_wr] <= side_last[side_rd];
                res_wr           <= res_wr + 1'b1;
                side_rd          <= side_rd + 1'b1;
                if (cbc_enc)
                    chain <= side_last[side_rd] ? iv_r : core_out_data;
            end

            case ({issue, result})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (m_fire)
                ob_cnt <= pop ? 2'd0 : ob_cnt + 1'b1;
            if (pop)
                res_rd <= res_rd + 1'b1;
            case ({result, pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: res_cnt <= res_cnt;
            endcase
        end
    end

`ifdef SM4_AXIS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_blocks <= '0;
            stat_pkts   <= '0;
        end else begin
            if (pop)
                stat_blocks <= stat_blocks + 1'b1;
            if (m_fire && m_axis_tlast)
                stat_pkts <= stat_pkts + 1'b1;
        end
    end
`endif
endmodule

// File: doc/sm4_axis_mode_ctrl.md
Name: sm4_axis_mode_ctrl

Overview:
Parametrised successor to the fixed 128-bit SM4 AXI-stream top. It accepts an AXI-stream of DATA_W-bit beats and packs them into 128-bit blocks. It drives an external SM4 block core in ECB or CBC mode, encrypt or decrypt, then unpacks the results to a DATA_W-bit master stream with full output backpressure. The block sits between the DMA/stream fabric and the SM4 core, and owns packet framing, chaining state and key/IV configuration.

Parameters:
DATA_W, 128, stream width; legal values 32, 64, 128; BEATS = 128/DATA_W.
DEPTH, 4, maximum blocks in flight plus buffered results; power of 2, range 2..16.
KEY_WAIT, 32, cycles after a key load before the first block is issued to the core.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_vld  in  1  config strobe; accepted only while cfg_rdy=1
cfg_rdy  out  1  high when idle and KEY_WAIT has elapsed
cfg_key  in  128  key
cfg_sel  in  1  0 = encrypt, 1 = decrypt
cfg_mode  in  1  0 = ECB, 1 = CBC
cfg_iv  in  128  CBC IV
s_axis_tdata  in  DATA_W  input beat
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  last beat of packet
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  output beat
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last beat of packet
m_axis_tready  in  1  output ready
core_key_vld  out  1  one-cycle key-load pulse
core_key  out  128  key to core
core_sel  out  1  mode to core
core_in_data  out  128  block to core
core_in_vld  out  1  block issue
core_in_rdy  in  1  core can accept a block
core_out_data  in  128  core result
core_out_vld  in  1  result valid; core has no backpressure
err_partial  out  1  sticky; a packet ended mid-block

Behaviour:
- Reset: all outputs 0, except cfg_rdy, which is 0 until KEY_WAIT cycles after reset release. All FIFOs empty, chain register 0, mode ECB, sel encrypt. Reset mid-packet discards all state and in-flight blocks. Core results arriving after reset are dropped.
- Beat order: big-endian. The first beat of a block holds bits [127:128-DATA_W]. Same order on output.
- Idle means: gearbox empty, in-flight count 0, result FIFO empty, output unpacker empty.
- Config: cfg_vld && cfg_rdy latches key, sel, mode and IV, and loads chain<=IV. core_key_vld pulses on the next cycle with core_key/core_sel valid. cfg_rdy then drops for KEY_WAIT cycles. cfg_vld while cfg_rdy=0 is ignored; no state change.
- Input gearbox: s_axis_tready=1 when the gearbox is not holding a completed block and the KEY_WAIT counter is 0. tlast on a non-final beat of a block zero-pads the remaining bits, sets err_partial, and the block is treated as last.
- Issue: a completed block goes to the core when core_in_rdy=1 and credit is available. Credit means in-flight count + result FIFO count < DEPTH. In CBC encrypt, issue additionally requires in-flight = 0.
  - ECB: core input = block.
  - CBC encrypt: core input = block XOR chain.
  - CBC decrypt: core input = block; chain value pushed to the side FIFO; chain <= block.
  - Every block pushes {last, mask} to the side FIFO. mask = 0 except in CBC decrypt.
- Result: on core_out_vld, pop the side FIFO and push core_out_data XOR mask plus last into the result FIFO. In CBC encrypt, chain <= core_out_data.
- After a last block is issued (decrypt) or completes (encrypt), chain reloads to the latched IV.
- Output unpacker: emits BEATS beats per result. m_axis_tlast is set on the final beat of a last block. tdata and tlast are held stable while tvalid && !tready.
- Latency: at most 1 cycle from the final input beat to core_in_vld, and 1 cycle from core_out_vld to the first m_axis beat, in the absence of backpressure.
- Simultaneous issue and result in the same cycle: the in-flight count is unchanged. Side FIFO and result FIFO push/pop in the same cycle are legal when full.

Optional Feature:
SM4_AXIS_STATS_EN: when defined, adds outputs stat_blocks (32) and stat_pkts (32). stat_blocks counts blocks emitted; stat_pkts counts output beats with tlast. Both wrap at 2^32, clear on rst, and do not clear on cfg. When undefined, these ports and counters are absent and the remaining behaviour is identical.

Test Plan:
1. DATA_W=32, ECB encrypt, key 0123456789abcdeffedcba9876543210. Input beats 01234567, 89abcdef, fedcba98, 76543210 with tlast -> output 681edf34, d206965e, 86b3e94f, 536e4246, with tlast on the 4th beat only.
2. DATA_W=128, ECB decrypt, same key, input 681edf34d206965e86b3e94f536e4246 -> output 0123456789abcdeffedcba9876543210.
3. CBC, IV=0, 3-block packet encrypt then decrypt with the same key/IV -> block 1 equals the ECB result, decrypt output equals the original plaintext, and chain reloads the IV for the next packet.
4. DEPTH=4, m_axis_tready held low for 40 cycles while 8 blocks stream in -> s_axis_tready stalls after 4 blocks in flight/buffered, no beat is lost or duplicated, and output order is preserved.
5. cfg_vld asserted mid-packet -> ignored (cfg_rdy=0). After idle, config is accepted, core_key_vld pulses once, and s_axis_tready stays low for KEY_WAIT cycles.
6. DATA_W=64, tlast on the 1st beat of a block -> err_partial=1, the block is padded with zeros, and the output has 2 beats with tlast on the 2nd. Then rst asserted mid-packet -> all outputs return to reset values.
